vend_ctrl: RTL
==============

VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter N_ITEMS, default 8: number of selectable products, one select bit each.
REQ-002 Parameter CW, default 11: width of all cent-valued quantities, unsigned.
REQ-003 Parameter TIMEOUT_CYC, default 50_000_000: idle cycles in PAY before automatic refund.
REQ-004 Parameter BLINK_CYC, default 25_000_000: half-period of blink output, in clk cycles.
REQ-005 clk  in  1  single system clock; all state updates on posedge clk.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 sel  in  N_ITEMS  product select switches, synchronised upstream.
REQ-008 price_tbl  in  N_ITEMS*CW  packed price per item in cents; item i at bits [i*CW +: CW].
REQ-009 coin_stb  in  1  one-cycle strobe: one coin inserted (debounced/edge-detected upstream).
REQ-010 coin_type  in  2  coin value when coin_stb is high: 0=5, 1=10, 2=25, 3=100 cents.
REQ-011 credit_stb  in  1  one-cycle strobe: operator free-vend override.
REQ-012 chg_ready  in  1  change dispenser accepts the current coin.
REQ-013 chg_valid  out  1  change coin offered.
REQ-014 chg_type  out  2  change coin value, same encoding as coin_type.
REQ-015 coin_reject  out  1  one-cycle pulse: inserted coin returned unaccepted.
REQ-016 vend_stb  out  1  one-cycle pulse: dispense product(s).
REQ-017 vend_sel  out  N_ITEMS  selection being dispensed; held from vend_stb until return to IDLE.
REQ-018 due  out  CW  amount still owed for the display; 0 when paid >= price.
REQ-019 blink  out  1  display blink enable.
REQ-020 state  out  2  IDLE=0, PAY=1, VEND=2, CHANGE=3.

Function
REQ-021 price = sum of price_tbl entries whose sel bit is 1; accumulation is (CW+log2(N_ITEMS)) bits wide; the result saturates at 2^CW-1.
REQ-022 paid is a CW-bit register; adding a coin saturates at 2^CW-1 and never wraps.
REQ-023 IDLE: paid=0, chg_valid=0; if sel!=0, go to PAY on the next cycle.
REQ-024 PAY: each accepted coin_stb adds its value to paid in the next cycle; price tracks sel live.
REQ-025 PAY: sel==0 -> CHANGE with refund=paid if paid>0, else IDLE.
REQ-026 PAY: paid>=price (evaluated on the registered paid) -> VEND in the next cycle, so a completing coin at cycle N yields vend_stb at cycle N+2.
REQ-027 PAY: credit_stb -> VEND with paid treated as price, so change=0; no other coin value is refunded.
REQ-028 PAY: TIMEOUT_CYC consecutive cycles without coin_stb -> CHANGE with refund=paid (IDLE if paid=0); each coin restarts the timer.
REQ-029 Priority in PAY when events coincide: credit_stb > sel==0 > paid>=price > timeout; coin_stb in the same cycle as credit_stb or sel==0 is rejected.
REQ-030 VEND lasts exactly 1 cycle: vend_stb=1, vend_sel latched, change=paid-price; next state is CHANGE if change>0, else IDLE.
REQ-031 coin_stb in VEND or CHANGE -> coin_reject=1 on the next cycle; paid is unchanged.
REQ-032 CHANGE: chg_valid=1 with chg_type set to the largest coin <= remaining change (greedy 100/25/10/5).
REQ-033 CHANGE handshake: the coin transfers on chg_valid&&chg_ready, and remaining is decremented that cycle.
REQ-034 chg_type stays stable while chg_valid&&!chg_ready.
REQ-035 CHANGE exits to IDLE the cycle after remaining reaches 0; sel and credit_stb are ignored in CHANGE.
REQ-036 Any residue below 5 cents (from non-multiple-of-5 prices) is discarded when remaining < 5.
REQ-037 due = (state==PAY && price>paid) ? price-paid : 0.
REQ-038 blink toggles every BLINK_CYC cycles while state==CHANGE; otherwise blink=0 and its counter is held at 0.

Reset
REQ-039 rst=1 at a posedge -> state=IDLE, paid=0, change=0, timer=0, blink counter=0.
REQ-040 Reset values are applied at that same posedge: all outputs 0, vend_sel=0, due=0.
REQ-041 rst overrides every other input, including mid-VEND and mid-CHANGE; any pending change is lost.

Verification
REQ-042 Prices {100,120,240,300,220,195,285,55}; sel=8'h20; coins 100,25,25,25,25 -> due 195,95,70,45,20,0; vend_stb once; change 5 as one 5-cent coin.
REQ-043 sel=8'h01, coin 100 with chg_ready=1 -> vend_stb 2 cycles after the strobe; no chg_valid; back to IDLE.
REQ-044 sel=8'h80, coins 25,25, then sel=0 -> CHANGE; two 25 coins; chg_ready held low 3 cycles keeps chg_type=2 stable.
REQ-045 sel=8'h08, coin 100, then credit_stb -> vend_stb, change 0; a coin during VEND -> coin_reject the next cycle.
REQ-046 TIMEOUT_CYC=16; sel=8'h02, coin 10, then 16 idle cycles -> CHANGE, one 10-cent coin; assert rst mid-CHANGE -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/vend_ctrl.sv
// vend_ctrl -- vending machine sequencer.
//
// Accumulates inserted coins against the summed price of the selected
// products, fires a one-cycle vend strobe once the price is covered (or on an
// operator free-vend), then pays change out one coin at a time through a
// valid/ready handshake using the largest coin that fits.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   sel           product select switches (one bit per item)
//   price_tbl     packed per-item prices in cents, item i at [i*CW +: CW]
//   coin_stb      one-cycle coin-inserted strobe, value in coin_type
//   coin_type     0=5, 1=10, 2=25, 3=100 cents
//   credit_stb    one-cycle operator free-vend strobe
//   chg_ready     change dispenser accepts the offered coin
//   chg_valid     change coin offered, value in chg_type
//   chg_type      change coin value, same encoding as coin_type
//   coin_reject   one-cycle pulse: inserted coin returned
//   vend_stb      one-cycle dispense pulse
//   vend_sel      selection being dispensed, held until back in IDLE
//   due           amount still owed while paying
//   blink         display blink enable during change payout
//   state         current FSM state
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | nothing selected, paid cleared
// PAY    | accepting coins against the live price of sel
// VEND   | single cycle: dispense, compute change
// CHANGE | paying change out coin by coin, blink running

module vend_ctrl #(
    parameter int N_ITEMS     = 8,
    parameter int CW          = 11,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int BLINK_CYC   = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_ITEMS-1:0]    sel,
    input  logic [N_ITEMS*CW-1:0] price_tbl,
    input  logic                  coin_stb,
    input  logic [1:0]            coin_type,
    input  logic                  credit_stb,
    input  logic                  chg_ready,
    output logic                  chg_valid,
    output logic [1:0]            chg_type,
    output logic                  coin_reject,
    output logic                  vend_stb,
    output logic [N_ITEMS-1:0]    vend_sel,
    output logic [CW-1:0]         due,
    output logic                  blink,
    output logic [1:0]            state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PAY    = 2'd1;
    localparam logic [1:0] S_VEND   = 2'd2;
    localparam logic [1:0] S_CHANGE = 2'd3;

    localparam int AW = CW + $clog2(N_ITEMS);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);
    localparam logic [CW-1:0] CW_MAX     = {CW{1'b1}};
    localparam logic [CW-1:0] V5         = CW'(5);
    localparam logic [CW-1:0] V10        = CW'(10);
    localparam logic [CW-1:0] V25        = CW'(25);
    localparam logic [CW-1:0] V100       = CW'(100);

    function automatic logic [CW-1:0] coin_value(input logic [1:0] t);
        logic [CW-1:0] v;
        case (t)
            2'd0:    v = V5;
            2'd1:    v = V10;
            2'd2:    v = V25;
            default: v = V100;
        endcase
        return v;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      paid_q, paid_d;
    logic [CW-1:0]      chg_q, chg_d;
    logic [CW-1:0]      price_lat_q, price_lat_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [N_ITEMS-1:0] vend_sel_q, vend_sel_d;
    logic               reject_q, reject_d;
    logic [BW-1:0]      blink_cnt;
    logic               blink_q;

    logic [AW-1:0]      price_sum;
    logic [CW-1:0]      price;
    logic [CW:0]        paid_sum;
    logic [CW-1:0]      paid_add;
    logic [1:0]         gtype;
    logic [CW-1:0]      chg_after;
    logic               coin_ok;

    // Live price of the current selection, saturated to CW bits.
    always_comb begin
        price_sum = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (sel[i]) begin
                price_sum = price_sum + AW'(price_tbl[i*CW +: CW]);
            end
        end
        price = (price_sum > AW'(CW_MAX)) ? CW_MAX : price_sum[CW-1:0];
    end

    assign paid_sum = {1'b0, paid_q} + {1'b0, coin_value(coin_type)};
    assign paid_add = paid_sum[CW] ? CW_MAX : paid_sum[CW-1:0];

    // Largest coin that fits in the remaining change.
    always_comb begin
        if (chg_q >= V100) begin
            gtype = 2'd3;
        end else if (chg_q >= V25) begin
            gtype = 2'd2;
        end else if (chg_q >= V10) begin
            gtype = 2'd1;
        end else begin
            gtype = 2'd0;
        end
    end

    assign chg_after = chg_q - coin_value(gtype);

    always_comb begin
        state_d     = state_q;
        paid_d      = paid_q;
        chg_d       = chg_q;
        price_lat_d = price_lat_q;
        timer_d     = timer_q;
        vend_sel_d  = vend_sel_q;
        reject_d    = 1'b0;
        coin_ok     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sel != '0) begin
                    state_d = S_PAY;
                    timer_d = TIMER_LOAD;
                end
            end

            S_PAY: begin
                coin_ok  = coin_stb && !credit_stb && (sel != '0);
                reject_d = coin_stb && !coin_ok;
                if (coin_ok) begin
                    paid_d  = paid_add;
                    timer_d = TIMER_LOAD;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end

                if (credit_stb) begin
                    // Free vend: pretend exactly the price was paid so no
                    // change results; coins already in are kept.
                    state_d     = S_VEND;
                    paid_d      = price;
                    price_lat_d = price;
                    vend_sel_d  = sel;
                end else if (sel == '0) begin
                    state_d = (paid_q != '0) ? S_CHANGE : S_IDLE;
                    chg_d   = paid_q;
                end else if (paid_q >= price) begin
                    // A coin accepted this same cycle still lands in paid and
                    // is returned as change from VEND.
                    state_d     = S_VEND;
                    price_lat_d = price;
                    vend_sel_d  = sel;
                end else if (!coin_stb && timer_q == '0) begin
                    state_d = (paid_q != '0) ? S_CHANGE : S_IDLE;
                    chg_d   = paid_q;
                end
            end

            S_VEND: begin
                reject_d = coin_stb;
                chg_d    = paid_q - price_lat_q;
                state_d  = (paid_q > price_lat_q) ? S_CHANGE : S_IDLE;
            end

            default: begin
                reject_d = coin_stb;
                if (chg_q < V5) begin
                    state_d = S_IDLE;
                end else if (chg_ready) begin
                    chg_d = chg_after;
                    if (chg_after < V5) begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase

        if (state_d != S_PAY) begin
            timer_d = '0;
        end
        if (state_d == S_IDLE) begin
            paid_d     = '0;
            chg_d      = '0;
            vend_sel_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            paid_q      <= '0;
            chg_q       <= '0;
            price_lat_q <= '0;
            timer_q     <= '0;
            vend_sel_q  <= '0;
            reject_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            paid_q      <= paid_d;
            chg_q       <= chg_d;
            price_lat_q <= price_lat_d;
            timer_q     <= timer_d;
            vend_sel_q  <= vend_sel_d;
            reject_q    <= reject_d;
        end
    end

    // Blink counter is cleared on the edge that leaves CHANGE so blink never
    // lingers into IDLE; it starts counting from the first CHANGE cycle.
    always_ff @(posedge clk) begin
        if (rst || state_d != S_CHANGE) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (state_q == S_CHANGE) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_q   <= ~blink_q;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    assign state       = state_q;
    assign vend_stb    = (state_q == S_VEND);
    assign vend_sel    = vend_sel_q;
    assign coin_reject = reject_q;
    assign chg_valid   = (state_q == S_CHANGE) && (chg_q >= V5);
    assign chg_type    = chg_valid ? gtype : 2'd0;
    assign due         = (state_q == S_PAY && price > paid_q) ? (price - paid_q) : '0;
    assign blink       = blink_q;

endmodule
